// File: rtl/aliens_prog_fetch.sv
// -----------------------------------------------------------------------------
// aliens_prog_fetch
//
// Program-ROM fetch controller for the Aliens CPU board. Turns CPU program
// byte reads (qualified by the decoder's active-low PROG select) into 16-bit
// word reads on the SDRAM port, keeps a one-word fetch buffer so the second
// byte of a word is served locally, owns the CPU bank latch and stalls the
// CPU through CPU_WAIT until the requested byte is on ROM_DATA.
//
// Ports
//   CLK, RESETn     clock, asynchronous active-low reset
//   CPU_A[15:0]     CPU byte address
//   CPU_RW          1 = read, 0 = write
//   PROG            active-low program-ROM select (AS already qualified)
//   BANK_WR         one-cycle strobe, loads CPU_DO[4:0] into the bank latch
//   CPU_DO[7:0]     CPU write data
//   BK4             bank latch bit 4, back to the decoder
//   ROM_DATA[7:0]   program byte to the CPU data mux
//   CPU_WAIT        active-high CPU stall
//   SD_REQ          SDRAM read request (level)
//   SD_ADDR         SDRAM word address, stable while SD_REQ=1
//   SD_RDY          one-cycle pulse, SD_DATA valid
//   SD_DATA[15:0]   SDRAM word, [15:8] even byte, [7:0] odd byte
// -----------------------------------------------------------------------------
module aliens_prog_fetch #(
    parameter int                  SDRAM_AW = 23,
    parameter logic [SDRAM_AW-1:0] ROM_BASE = '0
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic [15:0]         CPU_A,
    input  logic                CPU_RW,
    input  logic                PROG,
    input  logic                BANK_WR,
    input  logic [7:0]          CPU_DO,
    output logic                BK4,
    output logic [7:0]          ROM_DATA,
    output logic                CPU_WAIT,
    output logic                SD_REQ,
    output logic [SDRAM_AW-1:0] SD_ADDR,
    input  logic                SD_RDY,
    input  logic [15:0]         SD_DATA
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIT,
        ST_FETCH,
        ST_SERVED
    } state_t;

    state_t               state_q,    state_d;
    logic [4:0]           bk_q,       bk_d;
    logic [7:0]           rom_data_q, rom_data_d;
    logic                 sd_req_q,   sd_req_d;
    logic [SDRAM_AW-1:0]  sd_addr_q,  sd_addr_d;
    logic [16:0]          buf_wa_q,   buf_wa_d;
    logic [15:0]          buf_data_q, buf_data_d;
    logic                 buf_v_q,    buf_v_d;
    logic                 done_q,     done_d;
    logic [16:0]          cap_wa_q,   cap_wa_d;
    logic                 cap_ra0_q,  cap_ra0_d;

    logic [17:0]          ra;
    logic [16:0]          wa;
    logic                 rd_req;
    logic                 unused_do;

    // Only the low five bits of the CPU data bus reach the bank latch.
    assign unused_do = ^CPU_DO[7:5];

    // ROM byte address: the upper half of CPU space maps onto the top 32 KB
    // of ROM, the banked window selects one of 16 8 KB pages.
    assign ra     = CPU_A[15] ? {3'b111, CPU_A[14:0]}
                              : {1'b0, bk_q[3:0], CPU_A[12:0]};
    assign wa     = ra[17:1];
    assign rd_req = ~PROG & CPU_RW;

    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic odd);
        return odd ? word[7:0] : word[15:8];
    endfunction

    // -------------------------------------------------------------------------
    // Next-state and datapath decisions
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets its hold value first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d    = state_q;
        bk_d       = bk_q;
        rom_data_d = rom_data_q;
        sd_req_d   = sd_req_q;
        sd_addr_d  = sd_addr_q;
        buf_wa_d   = buf_wa_q;
        buf_data_d = buf_data_q;
        buf_v_d    = buf_v_q;
        done_d     = done_q;
        cap_wa_d   = cap_wa_q;
        cap_ra0_d  = cap_ra0_q;

        // The bank latch is independent of the fetch FSM; an access in
        // flight already holds its own captured word address.
        if (BANK_WR) begin
            bk_d = CPU_DO[4:0];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    cap_wa_d  = wa;
                    cap_ra0_d = ra[0];
                    if (buf_v_q && (buf_wa_q == wa)) begin
                        state_d = ST_HIT;
                    end else begin
                        state_d   = ST_FETCH;
                        sd_req_d  = 1'b1;
                        sd_addr_d = ROM_BASE + SDRAM_AW'(wa);
                    end
                end
            end

            ST_HIT: begin
                rom_data_d = pick_byte(buf_data_q, cap_ra0_q);
                done_d     = 1'b1;
                state_d    = ST_SERVED;
            end

            ST_FETCH: begin
                if (SD_RDY) begin
                    buf_data_d = SD_DATA;
                    buf_wa_d   = cap_wa_q;
                    buf_v_d    = 1'b1;
                    rom_data_d = pick_byte(SD_DATA, cap_ra0_q);
                    sd_req_d   = 1'b0;
                    // A CPU that has already left the cycle still gets the
                    // word buffered, but there is nobody left to release.
                    if (!PROG) begin
                        done_d  = 1'b1;
                        state_d = ST_SERVED;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_SERVED: begin
                if (PROG) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            // NOTE: the buffer is only a few flops, so it is reset with the
            // rest; buf_v is what actually guarantees no stale hit.
            state_q    <= ST_IDLE;
            bk_q       <= 5'h00;
            rom_data_q <= 8'hFF;
            sd_req_q   <= 1'b0;
            sd_addr_q  <= '0;
            buf_wa_q   <= '0;
            buf_data_q <= '0;
            buf_v_q    <= 1'b0;
            done_q     <= 1'b0;
            cap_wa_q   <= '0;
            cap_ra0_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed from the previous cycle's state.
            state_q    <= state_d;
            bk_q       <= bk_d;
            rom_data_q <= rom_data_d;
            sd_req_q   <= sd_req_d;
            sd_addr_q  <= sd_addr_d;
            buf_wa_q   <= buf_wa_d;
            buf_data_q <= buf_data_d;
            buf_v_q    <= buf_v_d;
            done_q     <= done_d;
            cap_wa_q   <= cap_wa_d;
            cap_ra0_q  <= cap_ra0_d;
        end
    end

    assign BK4      = bk_q[4];
    assign ROM_DATA = rom_data_q;
    assign SD_REQ   = sd_req_q;
    assign SD_ADDR  = sd_addr_q;

    // Stall only a CPU read that has not been served yet. With PROG high the
    // term is 0, which also covers IDLE on the cycle PROG rises and an
    // aborted fetch still waiting for SD_RDY.
    assign CPU_WAIT = rd_req & ~done_q;

endmodule

// File: tb/tb_aliens_prog_fetch.sv
// -----------------------------------------------------------------------------
// tb_aliens_prog_fetch
//
// Self-checking bench for aliens_prog_fetch. A small model tracks the bank
// latch and the fetch buffer; expected SDRAM addresses and ROM bytes are
// queued when a CPU read is issued and compared when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_aliens_prog_fetch;

    localparam int            AW   = 23;
    localparam logic [AW-1:0] BASE = '0;

    logic          clk;
    logic          rst_n;
    logic [15:0]   cpu_a;
    logic          cpu_rw;
    logic          prog;
    logic          bank_wr;
    logic [7:0]    cpu_do;
    logic          bk4;
    logic [7:0]    rom_data;
    logic          cpu_wait;
    logic          sd_req;
    logic [AW-1:0] sd_addr;
    logic          sd_rdy;
    logic [15:0]   sd_data;

    aliens_prog_fetch #(
        .SDRAM_AW (AW),
        .ROM_BASE (BASE)
    ) dut (
        .CLK      (clk),
        .RESETn   (rst_n),
        .CPU_A    (cpu_a),
        .CPU_RW   (cpu_rw),
        .PROG     (prog),
        .BANK_WR  (bank_wr),
        .CPU_DO   (cpu_do),
        .BK4      (bk4),
        .ROM_DATA (rom_data),
        .CPU_WAIT (cpu_wait),
        .SD_REQ   (sd_req),
        .SD_ADDR  (sd_addr),
        .SD_RDY   (sd_rdy),
        .SD_DATA  (sd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state and scoreboard queues.
    logic [4:0]    m_bk       = 5'h00;
    bit            m_buf_v    = 1'b0;
    logic [16:0]   m_buf_wa   = '0;
    logic [15:0]   m_buf_data = '0;
    logic [AW-1:0] addr_q[$];
    logic [7:0]    data_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] rom_addr(input logic [15:0] a, input logic [4:0] bk);
        return a[15] ? {3'b111, a[14:0]} : {1'b0, bk[3:0], a[12:0]};
    endfunction

    // Predict one CPU read: queue the SDRAM address on a miss and the byte the
    // CPU must see, updating the model buffer the way the hardware should.
    task automatic expect_access(input logic [15:0] a, input logic [15:0] word, output bit hit);
        logic [17:0] ra;
        ra  = rom_addr(a, m_bk);
        hit = m_buf_v && (m_buf_wa == ra[17:1]);
        if (!hit) begin
            addr_q.push_back(BASE + {6'b0, ra[17:1]});
            m_buf_v    = 1'b1;
            m_buf_wa   = ra[17:1];
            m_buf_data = word;
        end
        data_q.push_back(ra[0] ? m_buf_data[7:0] : m_buf_data[15:8]);
    endtask

    task automatic bank_write(input logic [7:0] v);
        @(negedge clk);
        bank_wr = 1'b1;
        cpu_do  = v;
        @(negedge clk);
        bank_wr = 1'b0;
        m_bk    = v[4:0];
        check("bk4", bk4, m_bk[4]);
    endtask

    // Full CPU read with an SDRAM responder that answers dly cycles after
    // SD_REQ is first seen (dly=0: in the same cycle the request rises).
    task automatic cpu_read(input logic [15:0] a, input logic [15:0] word, input int dly);
        bit            hit;
        bit            req_seen;
        int            waits;
        int            rdy_at;
        int            cyc;
        logic [AW-1:0] ea;
        expect_access(a, word, hit);
        @(negedge clk);
        cpu_a  = a;
        cpu_rw = 1'b1;
        prog   = 1'b0;
        #1 check("wait_rises", cpu_wait, 1'b1);
        waits    = 1;
        req_seen = 1'b0;
        rdy_at   = -1;
        cyc      = 0;
        while (cyc < 40) begin
            @(negedge clk);
            sd_rdy = 1'b0;
            if (!cpu_wait) break;
            waits++;
            if (sd_req && !req_seen) begin
                req_seen = 1'b1;
                rdy_at   = cyc + dly;
                if (addr_q.size() != 0) begin
                    ea = addr_q.pop_front();
                    check("sd_addr", sd_addr, ea);
                end
            end
            if (req_seen && cyc == rdy_at) begin
                sd_rdy  = 1'b1;
                sd_data = word;
            end
            cyc++;
        end
        if (!req_seen && addr_q.size() != 0) addr_q.delete(0);
        check("read_in_time", cyc < 40, 1'b1);
        check("sd_req_on_miss", req_seen, !hit);
        check("sd_req_dropped", sd_req, 1'b0);
        check("rom_data", rom_data, data_q.pop_front());
        check("wait_cycles", waits, hit ? 2 : dly + 2);
        prog   = 1'b1;
        sd_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            hit;
        int            cyc;
        logic [AW-1:0] ea;
        logic [17:0]   ra;

        rst_n   = 1'b0;
        cpu_a   = '0;
        cpu_rw  = 1'b1;
        prog    = 1'b1;
        bank_wr = 1'b0;
        cpu_do  = '0;
        sd_rdy  = 1'b0;
        sd_data = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_bk4", bk4, 1'b0);
        check("rst_rom_data", rom_data, 8'hFF);
        check("rst_sd_req", sd_req, 1'b0);
        check("rst_sd_addr", sd_addr, '0);
        check("rst_cpu_wait", cpu_wait, 1'b0);
        rst_n = 1'b1;

        bank_write(8'h13);

        // Fixed-region miss, then hit on the other byte of the same word.
        cpu_read(16'h8001, 16'hA55A, 5);
        cpu_read(16'h8000, 16'h0000, 0);

        // Banked reads: the bank change must force a new fetch.
        bank_write(8'h05);
        cpu_read(16'h2002, 16'h0F1E, 0);
        bank_write(8'h06);
        cpu_read(16'h2003, 16'hC3D2, 2);
        cpu_read(16'h2002, 16'h0000, 0);

        // Abort: PROG rises before SD_RDY; the word still lands in the buffer.
        expect_access(16'h8100, 16'h1234, hit);
        check("abort_is_miss", hit, 1'b0);
        @(negedge clk);
        cpu_a  = 16'h8100;
        cpu_rw = 1'b1;
        prog   = 1'b0;
        cyc    = 0;
        while (cyc < 20 && !sd_req) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_req_seen", sd_req, 1'b1);
        ea = addr_q.pop_front();
        check("abort_sd_addr", sd_addr, ea);
        prog = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_wait_low", cpu_wait, 1'b0);
        check("abort_req_held", sd_req, 1'b1);
        sd_rdy  = 1'b1;
        sd_data = 16'h1234;
        @(negedge clk);
        sd_rdy = 1'b0;
        check("abort_req_dropped", sd_req, 1'b0);
        check("abort_rom_data", rom_data, data_q.pop_front());
        cpu_read(16'h8101, 16'h0000, 0);

        // ROM write: never stalls, never requests.
        @(negedge clk);
        cpu_a  = 16'h9000;
        cpu_rw = 1'b0;
        prog   = 1'b0;
        #1 check("write_no_wait", cpu_wait, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("write_no_req", sd_req, 1'b0);
        end
        prog   = 1'b1;
        cpu_rw = 1'b1;

        // Stray SD_RDY with no request outstanding is ignored.
        @(negedge clk);
        sd_rdy  = 1'b1;
        sd_data = 16'hDEAD;
        @(negedge clk);
        sd_rdy = 1'b0;
        check("stray_rdy_rom_data", rom_data, 8'h34);

        // Reset in the middle of a fetch.
        @(negedge clk);
        cpu_a  = 16'h8001;
        cpu_rw = 1'b1;
        prog   = 1'b0;
        cyc    = 0;
        while (cyc < 20 && !sd_req) begin
            @(negedge clk);
            cyc++;
        end
        ra = rom_addr(16'h8001, m_bk);
        check("midrst_req_seen", sd_req, 1'b1);
        check("midrst_sd_addr", sd_addr, BASE + {6'b0, ra[17:1]});
        #2 rst_n = 1'b0;
        #1 check("midrst_req_async", sd_req, 1'b0);
        check("midrst_rom_data", rom_data, 8'hFF);
        prog    = 1'b1;
        m_bk    = 5'h00;
        m_buf_v = 1'b0;
        @(negedge clk);
        check("midrst_bk4", bk4, 1'b0);
        check("midrst_wait", cpu_wait, 1'b0);
        rst_n = 1'b1;

        // Same word as the buffered abort fetch: must miss after reset.
        cpu_read(16'h8101, 16'h5566, 1);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
